// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - time-multiplexed 8-digit hex display scanner with frame-aligned load
//
// Purpose:
//   Scans an 8-digit hex display one digit slot at a time. Each slot lasts
//   CLK_DIV clock cycles. A new 32-bit display value is accepted through a
//   valid/ready handshake and held pending. It is committed only at the end
//   of a frame (the digit 7 slot), so a frame never mixes old and new digits.
//
// Parameters:
//   CLK_DIV     clk cycles per digit slot (2 .. 2^20)
//
// Ports:
//   clk         sole clock, rising edge
//   rst         synchronous active-high reset
//   load_valid  load_data is offered this cycle
//   load_ready  block can accept a value this cycle
//   load_data   8 hex digits, digit k = bits [4k+3:4k]
//   nibble      value of the active digit (seg decoder input)
//   digit_sel   active-low one-hot digit enable, bit k = digit k
//   frame_done  one-cycle pulse as the digit 7 slot ends
//
// Build option:
//   SEG_SCAN_BLANK_EN  when defined, leading-zero digits (k >= 1) are blanked
//                      (digit_sel = 8'hFF); digit 0 is always lit.

module seg_scan #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_valid,
  output logic        load_ready,
  input  logic [31:0] load_data,
  output logic [3:0]  nibble,
  output logic [7:0]  digit_sel,
  output logic        frame_done
);

  // Prescaler width: enough bits to hold CLK_DIV-1, at least one bit.
  localparam int unsigned   PW        = (CLK_DIV <= 2) ? 1 : $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_MAX = PW'(CLK_DIV - 1);

  localparam logic [0:0] ST_EMPTY   = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;

  logic [PW-1:0] r_presc;
  logic [2:0]    r_idx;
  logic [31:0]   r_display;
  logic [31:0]   r_pending;
  logic [0:0]    r_state;
  logic [3:0]    r_nibble;
  logic [7:0]    r_digit_sel;

  logic          w_tick;
  logic          w_frame_done;
  logic          w_load_ready;
  logic          w_accept;
  logic          w_commit;
  logic [2:0]    w_idx_next;
  logic [31:0]   w_disp_next;
  logic [4:0]    w_bit_base;
  logic [3:0]    w_nibble_next;
  logic [7:0]    w_sel_next;

  assign w_tick = (r_presc == PRESC_MAX);

  // Handshake and frame pulse are forced low while rst is held so nothing
  // leaks out during reset, independent of the pre-reset register values.
  assign w_frame_done = !rst && w_tick && (r_idx == 3'd7);
  assign w_load_ready = !rst && (r_state == ST_EMPTY);
  assign w_accept     = load_valid && w_load_ready;
  assign w_commit     = (r_state == ST_PENDING) && w_frame_done;

  assign w_idx_next  = r_idx + 3'd1;

  // The digit 0 slot after a commit must already show the new value, so
  // the next-slot outputs look at the display as it will be after this edge.
  assign w_disp_next   = w_commit ? r_pending : r_display;
  assign w_bit_base    = {w_idx_next, 2'b00};
  assign w_nibble_next = w_disp_next[w_bit_base +: 4];

`ifdef SEG_SCAN_BLANK_EN
  logic w_blank;

  // Blank slot k when digits k..7 are all zero; digit 0 never blanks so a
  // zero display still shows a single "0".
  assign w_blank    = (w_idx_next != 3'd0) && ((w_disp_next >> w_bit_base) == 32'h0);
  assign w_sel_next = w_blank ? 8'hFF : ~(8'h01 << w_idx_next);
`else
  assign w_sel_next = ~(8'h01 << w_idx_next);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_presc     <= '0;
      r_idx       <= 3'd0;
      r_display   <= 32'h0;
      r_pending   <= 32'h0;
      r_state     <= ST_EMPTY;
      r_nibble    <= 4'h0;
      r_digit_sel <= 8'hFE;
    end else begin
      r_presc <= w_tick ? '0 : r_presc + PW'(1);

      // idx, nibble and digit_sel move together so they never disagree.
      if (w_tick) begin
        r_idx       <= w_idx_next;
        r_nibble    <= w_nibble_next;
        r_digit_sel <= w_sel_next;
      end

      if (w_commit) begin
        r_display <= r_pending;
      end

      if (w_accept) begin
        r_pending <= load_data;
      end

      // An accept that lands on a frame_done edge (EMPTY state) only moves
      // to PENDING; the commit waits for the following frame_done.
      case (r_state)
        ST_EMPTY:   if (w_accept) r_state <= ST_PENDING;
        ST_PENDING: if (w_commit) r_state <= ST_EMPTY;
        default:    r_state <= ST_EMPTY;
      endcase
    end
  end

  assign load_ready = w_load_ready;
  assign frame_done = w_frame_done;
  assign nibble     = r_nibble;
  assign digit_sel  = r_digit_sel;

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - self-checking bench for seg_scan with CLK_DIV=4

module tb_seg_scan;

  localparam int unsigned CLK_DIV = 4;

`ifdef SEG_SCAN_BLANK_EN
  localparam bit BLANK = 1'b1;
`else
  localparam bit BLANK = 1'b0;
`endif

  // data: display value; mask bit k: slot k is a leading-zero slot
  typedef struct {
    logic [31:0] data;
    logic [7:0]  mask;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [31:0] load_data = 32'h0;
  logic [3:0]  nibble;
  logic [7:0]  digit_sel;
  logic        frame_done;

  int   n_checks = 0;
  int   n_errors = 0;
  int   frame_no = 0;
  vec_t exp_q[$];
  vec_t tbl[7];

  seg_scan #(.CLK_DIV(CLK_DIV)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .load_data  (load_data),
    .nibble     (nibble),
    .digit_sel  (digit_sel),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [7:0] exp_sel(input vec_t v, input int k);
    logic [7:0] s;
    s = 8'h01 << k;
    s = ~s;
    if (BLANK && v.mask[k]) s = 8'hFF;
    return s;
  endfunction

  // Check one full frame starting at the first negedge of slot 0 and ending
  // at the negedge of the frame_done cycle.
  // mode 0: no load, 1: one-cycle load at slot 0, 2: load at slot 0 then keep
  // load_valid high with data ld2, 3: offer ld on the frame_done cycle.
  task automatic check_frame(input int mode, input vec_t ld, input logic [31:0] ld2);
    vec_t cur;
    cur = exp_q[0];
    frame_no++;
    for (int k = 0; k < 8; k++) begin
      for (int c = 0; c < CLK_DIV; c++) begin
        @(negedge clk);
        if (k == 0 && c == 0) begin
          chk($sformatf("ready_start f%0d", frame_no), 32'(load_ready),
              (exp_q.size() == 1) ? 32'd1 : 32'd0);
          if (mode == 1 || mode == 2) begin
            load_valid = 1'b1;
            load_data  = ld.data;
            exp_q.push_back(ld);
          end else begin
            load_valid = 1'b0;
          end
        end
        if (k == 0 && c == 1 && (mode == 1 || mode == 2)) begin
          chk($sformatf("ready_after_accept f%0d", frame_no), 32'(load_ready), 32'd0);
          if (mode == 1) load_valid = 1'b0;
          else           load_data  = ld2;
        end
        chk($sformatf("nibble f%0d k%0d c%0d", frame_no, k, c), 32'(nibble),
            32'(cur.data[4*k +: 4]));
        chk($sformatf("digit_sel f%0d k%0d c%0d", frame_no, k, c), 32'(digit_sel),
            32'(exp_sel(cur, k)));
        chk($sformatf("frame_done f%0d k%0d c%0d", frame_no, k, c), 32'(frame_done),
            (k == 7 && c == CLK_DIV - 1) ? 32'd1 : 32'd0);
        if (k == 7 && c == CLK_DIV - 1 && mode == 2) begin
          chk($sformatf("ready_held_low f%0d", frame_no), 32'(load_ready), 32'd0);
        end
      end
    end
    if (exp_q.size() > 1) void'(exp_q.pop_front());
    if (mode == 3) begin
      chk($sformatf("ready_on_frame_done f%0d", frame_no), 32'(load_ready), 32'd1);
      load_valid = 1'b1;
      load_data  = ld.data;
      exp_q.push_back(ld);
    end
  endtask

  task automatic check_in_reset(input string nm);
    chk({nm, " nibble"},     32'(nibble),     32'h0);
    chk({nm, " digit_sel"},  32'(digit_sel),  32'hFE);
    chk({nm, " frame_done"}, 32'(frame_done), 32'd0);
    chk({nm, " load_ready"}, 32'(load_ready), 32'd0);
  endtask

  vec_t none;
  vec_t v;

  initial begin
    tbl[0] = '{32'h89ABCDEF, 8'h00};
    tbl[1] = '{32'h00000000, 8'hFE};
    tbl[2] = '{32'h00000305, 8'hF8};
    tbl[3] = '{32'h12345678, 8'h00};
    tbl[4] = '{32'h80000000, 8'h00};
    tbl[5] = '{32'h00F00000, 8'hC0};
    tbl[6] = '{32'hFFFFFFFF, 8'h00};
    none   = '{32'h0, 8'h00};

    // Power-on reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_in_reset("reset");
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.push_back('{32'h0, 8'hFE});

    // Table: each frame shows the previous value and loads the next one
    for (int i = 0; i < 7; i++) begin
      check_frame(1, tbl[i], 32'h0);
    end
    check_frame(0, none, 32'h0);

    // Held load_valid while PENDING: only the first value is taken
    check_frame(2, '{32'h11111111, 8'h00}, 32'h22222222);
    check_frame(1, '{32'h22222222, 8'h00}, 32'h0);
    check_frame(0, none, 32'h0);

    // Accept on the frame_done cycle commits one frame later
    check_frame(3, '{32'h00000005, 8'hFE}, 32'h0);
    check_frame(0, none, 32'h0);
    check_frame(0, none, 32'h0);

    // Reset in slot 5 with a value pending: it must never appear
    v = exp_q[0];
    for (int cyc = 0; cyc < 22; cyc++) begin
      @(negedge clk);
      if (cyc == 0) begin
        chk("rst_seq ready_start", 32'(load_ready), 32'd1);
        load_valid = 1'b1;
        load_data  = 32'hDEADBEEF;
      end
      if (cyc == 1) begin
        load_valid = 1'b0;
        chk("rst_seq ready_pending", 32'(load_ready), 32'd0);
      end
      if (cyc == 20) begin
        chk("rst_seq digit_sel slot5", 32'(digit_sel), 32'(exp_sel(v, 5)));
        chk("rst_seq nibble slot5",    32'(nibble),    32'(v.data[23:20]));
      end
      if (cyc == 21) rst = 1'b1;
    end
    @(posedge clk);
    @(negedge clk);
    check_in_reset("mid_frame_reset");
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    exp_q.push_back('{32'h0, 8'hFE});
    check_frame(0, none, 32'h0);
    check_frame(0, none, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/seg_scan.md
SEG_SCAN -- requirements
Module: seg_scan

Interface
REQ-001 SHALL have parameter CLK_DIV, default 50000, clk cycles per digit slot (legal range 2..2^20).
REQ-002 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port load_valid  input  1  load_data is offered this cycle.
REQ-005 SHALL have port load_ready  output  1  block can accept a value this cycle.
REQ-006 SHALL have port load_data  input  32  8 hex digits; digit k = bits [4k+3:4k].
REQ-007 SHALL have port nibble  output  4  value of the active digit, fed to the seg decoder input.
REQ-008 SHALL have port digit_sel  output  8  active-low one-hot digit enable; bit k enables digit k.
REQ-009 SHALL have port frame_done  output  1  one-cycle pulse when the digit 7 slot ends.

Function
REQ-010 SHALL keep a prescaler counting 0..CLK_DIV-1 with wrap to 0; tick = prescaler==CLK_DIV-1.
REQ-011 SHALL keep a 3-bit digit index idx that advances by 1 on each tick and wraps from 7 to 0.
REQ-012 SHALL register nibble = display[4*idx+3:4*idx] and digit_sel = ~(1<<idx), both updated on the same edge as idx, so they never disagree.
REQ-013 SHALL assert frame_done for exactly the one cycle in which tick is high and idx==7.
REQ-014 SHALL implement a two-state load FSM: EMPTY (load_ready=1) and PENDING (load_ready=0).
REQ-015 SHALL, in EMPTY, on load_valid&&load_ready, capture load_data into a pending register and go to PENDING on the next edge.
REQ-016 SHALL, in PENDING, copy pending into display on the frame_done cycle, return to EMPTY, and assert load_ready on the following cycle.
REQ-017 SHALL never change display mid-frame; an update becomes visible starting with the digit 0 slot.
REQ-018 SHALL ignore load_valid while load_ready=0; load_data need not be held stable after acceptance.
REQ-019 SHALL, on an accept in the same cycle as frame_done (EMPTY state), hold the value until the next frame_done, with no early commit.
REQ-020 SHALL add load latency of 1 to 8*CLK_DIV cycles from accept to commit; the scan timing is independent of loads.

Reset
REQ-021 SHALL, while rst=1 at a clock edge, set prescaler=0, idx=0, display=0, pending=0, FSM=EMPTY.
REQ-022 SHALL drive nibble=4'h0, digit_sel=8'hFE, frame_done=0, load_ready=0 during reset; load_ready=1 on the first cycle after rst falls.
REQ-023 SHALL discard a PENDING value on reset mid-frame; display reads 0 after reset.

Configuration
REQ-024 SHALL implement leading-zero blanking when the macro SEG_SCAN_BLANK_EN is defined: during slot k (k>=1), digit_sel=8'hFF if all display nibbles k..7 are zero; digit 0 is always enabled.
REQ-025 SHALL drive all 8 digits in their slots when SEG_SCAN_BLANK_EN is undefined; idx, nibble, frame_done and timing are identical in both builds.

Verification
REQ-026 SHALL check that with CLK_DIV=4 after reset, digit_sel steps FE,FD,FB,F7,EF,DF,BF,7F every 4 cycles and frame_done pulses once per 32 cycles.
REQ-027 SHALL check that loading 32'h89ABCDEF in EMPTY gives load_ready=0 next cycle, old display shown until frame_done, then nibble sequence F,E,D,C,B,A,9,8, and load_ready=1 one cycle after commit.
REQ-028 SHALL check that holding load_valid=1 with 32'h11111111 then 32'h22222222 while PENDING accepts only the first value; the second is accepted only after load_ready returns.
REQ-029 SHALL check that an accept of 32'h00000005 on the frame_done cycle is not visible in the immediate next frame and is visible in the frame after.
REQ-030 SHALL check that asserting rst in the idx=5 slot with a value PENDING gives digit_sel=FE and nibble=0 after reset, and that the pending value never appears.
REQ-031 SHALL check that with SEG_SCAN_BLANK_EN and display=32'h00000305, digit_sel=FF in slots 3..7, active in slots 0..2, and digit 0 stays active for display=0.
